ifu_fetch_hs: RTL and testbench

- Multi-cycle successor to the fixed-step PC-increment IFU.
- Drives a valid/ready instruction-memory request channel and accepts the response one or more cycles later.
- Buffers fetched {pc, inst, err} in a parametrised FIFO and presents them to IDU over a valid/ready interface.
- Supports redirect (jump/branch/trap) with flush and squashing of the in-flight response. Sits between instruction memory and IDU in the NPC.

---
 rtl/ifu_fetch_hs_pkg.sv | 13 +
 rtl/ifu_fetch_hs_if.sv | 39 +++
 rtl/ifu_fetch_hs_fifo.sv | 54 +++++
 rtl/ifu_fetch_hs.sv | 107 ++++++++++
 tb/tb_ifu_fetch_hs.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_hs_pkg.sv
// Shared definitions for the handshaked instruction-fetch unit: FSM encoding
// and the default reset vector.
package ifu_fetch_hs_pkg;

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } ifu_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ifu_fetch_hs_if.sv
// Handshake bundle around the IFU: imem request/response, EXU redirect and the
// IDU-facing instruction stream. master = IFU side, slave = environment side.
interface ifu_fetch_hs_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [PC_W-1:0]   imem_req_addr;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_data;
   logic              imem_resp_err;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_err;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data, imem_resp_err,
      input  redirect_valid, redirect_pc,
      output out_valid, out_pc, out_inst, out_err,
      input  out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data, imem_resp_err,
      output redirect_valid, redirect_pc,
      input  out_valid, out_pc, out_inst, out_err,
      output out_ready
   );

endinterface

// File: rtl/ifu_fetch_hs_fifo.sv
// Small synchronous FIFO for fetched {pc, inst, err} entries with flush.
// Only pointers and count are reset; the storage array is data.
module ifu_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         // Flush wins over any push/pop in the same cycle.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ifu_fetch_hs.sv
// Instruction fetch unit: one-outstanding imem request FSM feeding a small
// instruction buffer toward IDU, with redirect flush and in-flight squash.
module ifu_fetch_hs
   import ifu_fetch_hs_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              INST_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
   parameter int              DEPTH    = 2
) (
   input  logic           clk,
   input  logic           rst,
   ifu_fetch_hs_if.master bus
);
   localparam int ENT_W = PC_W + INST_W + 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   ifu_state_e        state, state_n;
   logic [PC_W-1:0]   fetch_pc, fetch_pc_n;
   logic [PC_W-1:0]   req_pc;
   logic [PC_W-1:0]   redirect_tgt;
   logic              drop, drop_n;
   logic              req_valid;
   logic              hs;
   logic              push;
   logic              pop;
   logic [ENT_W-1:0]  head;
   logic [CNT_W-1:0]  count;
   logic              has_entry;

   assign redirect_tgt = bus.redirect_pc & ~PC_W'(3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         drop     <= 1'b0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         drop     <= drop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (hs) req_pc <= fetch_pc;
   end

   // A request is only issued when a buffer slot is free, so the eventual
   // response can always be pushed even while IDU stalls.
   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      drop_n     = drop;
      req_valid  = 1'b0;
      hs         = 1'b0;
      push       = 1'b0;
      case (state)
         S_REQ: begin
            req_valid = rst && (count < CNT_W'(DEPTH));
            hs        = req_valid && bus.imem_req_ready;
            if (hs) begin
               fetch_pc_n = fetch_pc + PC_W'(PC_STEP);
               state_n    = S_WAIT;
               drop_n     = bus.redirect_valid;
            end
         end
         S_WAIT: begin
            if (bus.imem_resp_valid) begin
               push    = !drop && !bus.redirect_valid;
               state_n = S_REQ;
               drop_n  = 1'b0;
            end else if (bus.redirect_valid) begin
               drop_n = 1'b1;
            end
         end
         default: state_n = S_REQ;
      endcase
      if (bus.redirect_valid) fetch_pc_n = redirect_tgt;
   end

   assign has_entry = (count != '0);
   assign pop       = has_entry && bus.out_ready;

   ifu_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .din   ({req_pc, bus.imem_resp_data, bus.imem_resp_err}),
      .dout  (head),
      .count (count)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc;
   assign bus.out_valid      = has_entry;
   assign {bus.out_pc, bus.out_inst, bus.out_err} = has_entry ? head : '0;

   resp_only_in_wait: assert property (
      @(posedge clk) disable iff (!rst) !(state == S_REQ && bus.imem_resp_valid));

endmodule

// File: tb/tb_ifu_fetch_hs.sv
// Randomized bench for ifu_fetch_hs: a responding memory plus a queue-based
// reference of the fetch stream, with directed scenarios for the corner cases.
module tb_ifu_fetch_hs;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int DEPTH  = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifu_fetch_hs_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

   ifu_fetch_hs #(
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .RESET_PC (32'h8000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   bit          m_out;
   bit          m_drop;

   // memory model state
   bit          mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;
   int          min_lat, max_lat, p_err;
   logic [31:0] err_addr;

   logic [31:0] hs_log[$];
   ent_t        pop_log[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.imem_resp_err   = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.out_ready       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      m_q.delete();
      m_pc     = 32'h8000_0000;
      m_out    = 1'b0;
      m_drop   = 1'b0;
      m_addr   = '0;
      mem_busy = 1'b0;
      mem_wait = 0;
      mem_addr = '0;
      err_addr = 32'h1;
      p_err    = 0;
      hs_log.delete();
      pop_log.delete();
      #1;
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_pc",    64'(bus.out_pc), 64'(0));
      chk("rst_out_inst",  64'(bus.out_inst), 64'(0));
      chk("rst_out_err",   64'(bus.out_err), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   // One cycle: compare outputs with the model, drive inputs, advance the model.
   task automatic step(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
      bit          exp_rv, hs, rv, pop, rerr, dut_hs;
      logic [31:0] rdata;
      ent_t        e;
      exp_rv = !m_out && (m_q.size() < DEPTH);
      chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
      chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("out_pc",   64'(bus.out_pc),   64'(m_q[0].pc));
         chk("out_inst", 64'(bus.out_inst), 64'(m_q[0].inst));
         chk("out_err",  64'(bus.out_err),  64'(m_q[0].err));
      end

      rv    = mem_busy && (mem_wait == 0);
      rdata = $urandom;
      rerr  = rv && ((mem_addr == err_addr) || ($urandom_range(0, 99) < p_err));
      bus.imem_req_ready  = rdy;
      bus.imem_resp_valid = rv;
      bus.imem_resp_data  = rdata;
      bus.imem_resp_err   = rerr;
      bus.redirect_valid  = redir;
      bus.redirect_pc     = rpc;
      bus.out_ready       = ordy;

      dut_hs = bus.imem_req_valid && rdy;
      if (dut_hs) hs_log.push_back(bus.imem_req_addr);
      if (bus.out_valid && ordy && !redir) begin
         e.pc = bus.out_pc; e.inst = bus.out_inst; e.err = bus.out_err;
         pop_log.push_back(e);
      end

      hs  = exp_rv && rdy;
      pop = (m_q.size() != 0) && ordy;
      if (redir) m_q.delete();
      else begin
         if (pop) void'(m_q.pop_front());
         if (m_out && rv && !m_drop) begin
            e.pc = m_addr; e.inst = rdata; e.err = rerr;
            m_q.push_back(e);
         end
      end
      if (m_out) begin
         if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
         else if (redir) m_drop = 1'b1;
      end else if (hs) begin
         m_out  = 1'b1;
         m_addr = m_pc;
         m_drop = redir;
         m_pc   = m_pc + 32'd4;
      end
      if (redir) m_pc = rpc & ~32'd3;

      if (rv) mem_busy = 1'b0;
      else if (mem_busy && mem_wait > 0) mem_wait--;
      if (dut_hs) begin
         mem_busy = 1'b1;
         mem_addr = bus.imem_req_addr;
         mem_wait = $urandom_range(min_lat, max_lat);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n, input bit rdy, input bit ordy);
      for (int i = 0; i < n; i++) step(rdy, ordy, 1'b0, 32'h0);
   endtask

   initial begin
      int idx, bad, guard;
      int p_rdy, p_ordy, p_redir;
      idle_inputs();
      #2;

      // in-order stream with an always-ready 1-cycle memory
      do_reset();
      min_lat = 0; max_lat = 0;
      run(10, 1'b1, 1'b1);
      chk("s1_hs_cnt", 64'(hs_log.size() >= 3), 64'(1));
      if (hs_log.size() >= 3) begin
         chk("s1_addr0", 64'(hs_log[0]), 64'h8000_0000);
         chk("s1_addr1", 64'(hs_log[1]), 64'h8000_0004);
         chk("s1_addr2", 64'(hs_log[2]), 64'h8000_0008);
      end

      // IDU stall fills the buffer, then drains in order
      do_reset();
      run(10, 1'b1, 1'b0);
      chk("s2_req_held", 64'(bus.imem_req_valid), 64'(0));
      chk("s2_head_pc",  64'(bus.out_pc), 64'h8000_0000);
      chk("s2_hs_cnt",   64'(hs_log.size()), 64'(2));
      run(8, 1'b1, 1'b1);
      chk("s2_pop_cnt", 64'(pop_log.size() >= 2 && hs_log.size() >= 3), 64'(1));
      if (pop_log.size() >= 2 && hs_log.size() >= 3) begin
         chk("s2_pop0", 64'(pop_log[0].pc), 64'h8000_0000);
         chk("s2_pop1", 64'(pop_log[1].pc), 64'h8000_0004);
         chk("s2_resume", 64'(hs_log[2]), 64'h8000_0008);
      end

      // redirect while waiting on a slow response
      do_reset();
      min_lat = 2; max_lat = 2;
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h8000_1002);
      run(12, 1'b1, 1'b1);
      chk("s3_cnt", 64'(hs_log.size() >= 2 && pop_log.size() >= 1), 64'(1));
      if (hs_log.size() >= 2 && pop_log.size() >= 1) begin
         chk("s3_next_req", 64'(hs_log[1]), 64'h8000_1000);
         chk("s3_first_pop", 64'(pop_log[0].pc), 64'h8000_1000);
      end

      // redirect coinciding with the handshake at 0x80000008
      do_reset();
      min_lat = 0; max_lat = 0;
      guard = 0;
      while (!(!m_out && m_pc == 32'h8000_0008) && guard < 20) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         guard++;
      end
      step(1'b1, 1'b1, 1'b1, 32'h8000_2000);
      run(10, 1'b1, 1'b1);
      idx = -1;
      foreach (hs_log[i]) if (idx < 0 && hs_log[i] == 32'h8000_0008) idx = i;
      chk("s4_hs08_seen", 64'(idx >= 0 && idx + 1 < hs_log.size()), 64'(1));
      if (idx >= 0 && idx + 1 < hs_log.size())
         chk("s4_next_req", 64'(hs_log[idx+1]), 64'h8000_2000);
      bad = 0;
      foreach (pop_log[i]) if (pop_log[i].pc == 32'h8000_0008) bad++;
      chk("s4_no_08", 64'(bad), 64'(0));

      // access fault on a single fetch
      do_reset();
      err_addr = 32'h8000_0004;
      run(12, 1'b1, 1'b1);
      chk("s5_cnt", 64'(pop_log.size() >= 3), 64'(1));
      if (pop_log.size() >= 3) begin
         chk("s5_pc1",  64'(pop_log[1].pc), 64'h8000_0004);
         chk("s5_err1", 64'(pop_log[1].err), 64'(1));
         chk("s5_pc2",  64'(pop_log[2].pc), 64'h8000_0008);
         chk("s5_err2", 64'(pop_log[2].err), 64'(0));
      end

      // asynchronous reset in S_WAIT with one entry buffered
      do_reset();
      min_lat = 2; max_lat = 2;
      guard = 0;
      while (!(m_out && m_q.size() == 1) && guard < 20) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         guard++;
      end
      chk("s6_setup", 64'(m_out && m_q.size() == 1), 64'(1));
      #2 rst = 1'b0;
      #1;
      chk("s6_async_out_valid", 64'(bus.out_valid), 64'(0));
      chk("s6_async_out_pc",    64'(bus.out_pc), 64'(0));
      chk("s6_async_req_valid", 64'(bus.imem_req_valid), 64'(0));
      @(negedge clk);
      do_reset();
      min_lat = 0; max_lat = 0;
      run(10, 1'b1, 1'b1);
      chk("s6_cnt", 64'(hs_log.size() >= 1 && pop_log.size() >= 1), 64'(1));
      if (hs_log.size() >= 1 && pop_log.size() >= 1) begin
         chk("s6_first_req", 64'(hs_log[0]), 64'h8000_0000);
         chk("s6_first_pop", 64'(pop_log[0].pc), 64'h8000_0000);
      end

      // randomized traffic under varying memory/IDU behaviour
      for (int ph = 0; ph < 3; ph++) begin
         do_reset();
         case (ph)
            0: begin p_rdy = 100; p_ordy = 100; p_redir = 2; min_lat = 0; max_lat = 0; end
            1: begin p_rdy = 60;  p_ordy = 40;  p_redir = 5; min_lat = 0; max_lat = 3; end
            default: begin p_rdy = 80; p_ordy = 20; p_redir = 8; min_lat = 1; max_lat = 2; end
         endcase
         p_err = 10 * (ph + 1);
         for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_ordy,
                 $urandom_range(0, 99) < p_redir, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
